// File: rtl/glyph_blitter.sv
// Streams enabled glyph slots, one pixel per clock, into a vga_adapter x/y/colour/plot port.
// Optional macro GLYPH_BLITTER_ROUND_CORNERS_EN suppresses plotting of the four cell corners.
module glyph_blitter #(
    parameter int GLYPH_W     = 5,
    parameter int GLYPH_H     = 5,
    parameter int PAD         = 1,
    parameter int NUM_SLOTS   = 4,
    parameter int COLOUR_BITS = 3,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120
) (
    input  logic                                              CLOCK_50,
    input  logic                                              reset,
    input  logic                                              start,
    input  logic                                              loop,
    input  logic                                              slot_we,
    input  logic [((NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1)-1:0] slot_addr,
    input  logic [7:0]                                        slot_x,
    input  logic [6:0]                                        slot_y,
    input  logic [GLYPH_W*GLYPH_H-1:0]                        slot_bitmap,
    input  logic [COLOUR_BITS-1:0]                            slot_fg,
    input  logic [COLOUR_BITS-1:0]                            slot_bg,
    input  logic                                              slot_en,
    output logic                                              busy,
    output logic                                              done,
    output logic [7:0]                                        x,
    output logic [6:0]                                        y,
    output logic [COLOUR_BITS-1:0]                            colour,
    output logic                                              plot
);

    localparam int SW  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int BMW = GLYPH_W * GLYPH_H;
    localparam int CW  = GLYPH_W + 2 * PAD;
    localparam int CH  = GLYPH_H + 2 * PAD;
    localparam logic [7:0]    CW_M1  = 8'(CW - 1);
    localparam logic [7:0]    CH_M1  = 8'(CH - 1);
    localparam logic [7:0]    PAD_L  = 8'(PAD);
    localparam logic [7:0]    GX_END = 8'(PAD + GLYPH_W);
    localparam logic [7:0]    GY_END = 8'(PAD + GLYPH_H);
    localparam logic [SW-1:0] LAST_S = SW'(NUM_SLOTS - 1);

    typedef enum logic [1:0] {IDLE, SETUP, PIXEL, FIN} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          s_q, s_d;
    logic [7:0]             cx_q, cx_d, cy_q, cy_d;
    logic [7:0]             x_q, x_d;
    logic [6:0]             y_q, y_d;
    logic [COLOUR_BITS-1:0] colour_q, colour_d;
    logic                   plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic [7:0]             sx_q  [NUM_SLOTS];
    logic [7:0]             sx_d  [NUM_SLOTS];
    logic [6:0]             sy_q  [NUM_SLOTS];
    logic [6:0]             sy_d  [NUM_SLOTS];
    logic [BMW-1:0]         sbm_q [NUM_SLOTS];
    logic [BMW-1:0]         sbm_d [NUM_SLOTS];
    logic [COLOUR_BITS-1:0] sfg_q [NUM_SLOTS];
    logic [COLOUR_BITS-1:0] sfg_d [NUM_SLOTS];
    logic [COLOUR_BITS-1:0] sbg_q [NUM_SLOTS];
    logic [COLOUR_BITS-1:0] sbg_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]   sen_q, sen_d;

    // Slot table only changes while idle so a pass always sees a stable snapshot.
    always_comb begin
        sx_d  = sx_q;
        sy_d  = sy_q;
        sbm_d = sbm_q;
        sfg_d = sfg_q;
        sbg_d = sbg_q;
        sen_d = sen_q;
        if (slot_we && (state_q == IDLE) && (32'(slot_addr) < NUM_SLOTS)) begin
            sx_d[slot_addr]  = slot_x;
            sy_d[slot_addr]  = slot_y;
            sbm_d[slot_addr] = slot_bitmap;
            sfg_d[slot_addr] = slot_fg;
            sbg_d[slot_addr] = slot_bg;
            sen_d[slot_addr] = slot_en;
        end
    end

    logic [8:0]     x_sum;
    logic [7:0]     y_sum, gx, gy;
    logic [15:0]    bit_idx;
    logic [BMW-1:0] bm_sh;
    logic           is_pad, in_screen;

    always_comb begin
        x_sum     = 9'(sx_q[s_q]) + 9'(cx_q);
        y_sum     = 8'(sy_q[s_q]) + cy_q;
        is_pad    = (cx_q < PAD_L) || (cx_q >= GX_END) || (cy_q < PAD_L) || (cy_q >= GY_END);
        gx        = cx_q - PAD_L;
        gy        = cy_q - PAD_L;
        bit_idx   = 16'(BMW - 1) - (16'(gy) * 16'(GLYPH_W) + 16'(gx));
        bm_sh     = sbm_q[s_q] >> bit_idx;
        in_screen = (x_sum < 9'(SCREEN_W)) && (y_sum < 8'(SCREEN_H));
    end

`ifdef GLYPH_BLITTER_ROUND_CORNERS_EN
    logic is_corner;
    assign is_corner = ((cx_q == 8'd0) || (cx_q == CW_M1)) && ((cy_q == 8'd0) || (cy_q == CH_M1));
`endif

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETUP;
                    s_d     = '0;
                end
            end
            SETUP: begin
                if (sen_q[s_q]) begin
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = PIXEL;
                end else if (s_q == LAST_S) begin
                    state_d = FIN;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            PIXEL: begin
                x_d      = x_sum[7:0];
                y_d      = y_sum[6:0];
                colour_d = (!is_pad && bm_sh[0]) ? sfg_q[s_q] : sbg_q[s_q];
`ifdef GLYPH_BLITTER_ROUND_CORNERS_EN
                plot_d   = in_screen && !is_corner;
`else
                plot_d   = in_screen;
`endif
                if (cx_q == CW_M1) begin
                    cx_d = '0;
                    if (cy_q == CH_M1) begin
                        if (s_q == LAST_S) begin
                            state_d = FIN;
                        end else begin
                            s_d     = s_q + 1'b1;
                            state_d = SETUP;
                        end
                    end else begin
                        cy_d = cy_q + 8'd1;
                    end
                end else begin
                    cx_d = cx_q + 8'd1;
                end
            end
            FIN: begin
                done_d = 1'b1;
                if (loop) begin
                    state_d = SETUP;
                    s_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            s_q      <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sen_q    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                sx_q[i]  <= '0;
                sy_q[i]  <= '0;
                sbm_q[i] <= '0;
                sfg_q[i] <= '0;
                sbg_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sen_q    <= sen_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            sbm_q    <= sbm_d;
            sfg_q    <= sfg_d;
            sbg_q    <= sbg_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;

endmodule

// File: doc/glyph_blitter.md
Name: glyph_blitter

Overview:
- Parametrised successor to the fixed lampboard/wheel painter.
- Holds NUM_SLOTS glyph slots. Each slot has a position, a bitmap, foreground/background colours and an enable bit.
- On request, streams every enabled slot pixel by pixel into the vga_adapter x/y/colour/plot port at one pixel per clock.
- Sits between the Enigma state logic (which writes the slots) and vga_adapter.

Parameters:
- GLYPH_W, 5, glyph bitmap width in pixels.
- GLYPH_H, 5, glyph bitmap height in pixels.
- PAD, 1, background border width around the glyph, on every side.
- NUM_SLOTS, 4, number of glyph slots; must be at least 1.
- COLOUR_BITS, 3, colour width.
- SCREEN_W, 160, horizontal clip limit.
- SCREEN_H, 120, vertical clip limit.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request one frame pass; sampled only in IDLE.
- loop  in  1  when high at the end of a pass, the next pass starts immediately.
- slot_we  in  1  slot write strobe.
- slot_addr  in  clog2(NUM_SLOTS) (min 1)  slot index to write.
- slot_x  in  8  cell top-left x.
- slot_y  in  7  cell top-left y.
- slot_bitmap  in  GLYPH_W*GLYPH_H  row-major bitmap; MSB is the top-left pixel.
- slot_fg  in  COLOUR_BITS  colour for bitmap 1s.
- slot_bg  in  COLOUR_BITS  colour for bitmap 0s and for the pad.
- slot_en  in  1  slot enable.
- busy  out  1  pass in progress.
- done  out  1  one-cycle pulse at the end of each pass.
- x  out  8  pixel x, to vga_adapter.
- y  out  7  pixel y, to vga_adapter.
- colour  out  COLOUR_BITS  pixel colour.
- plot  out  1  pixel write strobe.

Behaviour:
- Cell size: CW = GLYPH_W + 2*PAD and CH = GLYPH_H + 2*PAD (7x7 with defaults).
- Reset: all slots cleared (en=0, other fields 0); FSM goes to IDLE. x=0, y=0, colour=0, plot=0, busy=0, done=0.
- Reset asserted mid-pass aborts the pass at once: no done pulse, plot drops asynchronously.
- All outputs are registered.
- Slot writes:
  - slot_we in IDLE updates slot[slot_addr] on the clock edge.
  - slot_we while busy is ignored; slot contents are stable for the whole pass.
  - slot_addr >= NUM_SLOTS is ignored.
- FSM states: IDLE, SETUP, PIXEL, FIN.
- IDLE:
  - busy=0, plot=0.
  - If start=1, go to SETUP with slot index s=0 and set busy=1.
- SETUP: one cycle per slot, with plot=0.
  - If slot[s].en=1, clear the cell counters (cx=0, cy=0) and go to PIXEL.
  - Otherwise, if s is the last slot go to FIN; else s+1 and stay in SETUP.
- PIXEL: one cycle per cell pixel, raster order with cx fastest.
  - x = slot_x + cx and y = slot_y + cy, computed in 9 and 8 bits.
  - Pad pixel (cx<PAD, cx>=PAD+GLYPH_W, cy<PAD or cy>=PAD+GLYPH_H): colour = bg.
  - Glyph pixel: bit index GLYPH_W*GLYPH_H-1-((cy-PAD)*GLYPH_W+(cx-PAD)); colour = fg if the bit is 1, else bg.
  - plot=1 unless the 9/8-bit sum is >= SCREEN_W or >= SCREEN_H. A clipped pixel still takes its cycle, with plot=0 and x/y truncated.
  - After cx=CW-1 and cy=CH-1: if s is the last slot go to FIN; else s+1 and go to SETUP.
- FIN: one cycle; done=1, plot=0.
  - If loop=1, go to SETUP with s=0 and keep busy=1.
  - Otherwise go to IDLE with busy=0.
- Timing, with E enabled slots:
  - start sampled at edge k.
  - busy is high for NUM_SLOTS + E*CW*CH + 1 cycles, from edge k+1 through FIN inclusive.
  - done is high during the FIN cycle only.
  - The first pixel is presented at edge k+2 when slot 0 is enabled.
- start asserted in SETUP/PIXEL/FIN is ignored.
- With zero slots enabled: NUM_SLOTS SETUP cycles, then FIN with done; no plot at any point.

Optional Feature:
- Macro: GLYPH_BLITTER_ROUND_CORNERS_EN.
- Defined: the four corner pixels of each cell, (0,0), (CW-1,0), (0,CH-1) and (CW-1,CH-1), have plot forced to 0. Cycle count is unchanged.
- Undefined: corner pixels plot normally as bg, subject to clipping.

Test Plan:
- Basic pass:
  - Stimulus: slot0 = (28,35), bitmap 25'b00100_01010_01110_01010_01010, fg=3'b110, bg=3'b000, en=1; slots 1-3 disabled; pulse start.
  - Required: busy high 4+49+1=54 cycles; done pulses once.
  - Required: 49 plots; the pixel at (30,36) has colour 000 and the pixel at (31,36) has colour 110.
- Clipping:
  - Stimulus: slot0 at x=157, y=0, en=1; pass.
  - Required: exactly 21 plots, all with x in 157..159; cycle count is still 54.
- Disabled slots and write during busy:
  - Stimulus: all slots disabled; start; during SETUP, write slot2 en=1.
  - Required: 5 busy cycles, zero plots, done once; slot2 still disabled on the next pass.
- Loop:
  - Stimulus: loop=1; two slots enabled.
  - Required: done pulses every 4+98+1=103 cycles, with busy continuously high.
  - Stimulus: drop loop.
  - Required: returns to IDLE after the next FIN.
- Reset mid-pass:
  - Stimulus: assert reset at pixel 20 of slot0.
  - Required: plot=0 and busy=0 immediately; no done pulse; all slots cleared.
- Round corners:
  - Stimulus: GLYPH_BLITTER_ROUND_CORNERS_EN defined; the basic-pass scenario.
  - Required: 45 plots; no plot at (28,35), (34,35), (28,41) or (34,41).
